// File: rtl/line_mem_responder_pkg.sv
// Shared line geometry and FSM state type for the line memory responder and the caches it serves.
package line_mem_responder_pkg;

  localparam int LINE_LEN   = 128;
  localparam int LINE_BYTES = LINE_LEN / 8;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int COUNT_W    = 8;

  typedef logic [LINE_LEN-1:0]   line_t;
  typedef logic [LINE_BYTES-1:0] strobe_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_BUSY,
    WR_BUSY
  } mem_state_e;

endpackage

// File: rtl/axi_bus_rw.sv
// 128-bit cache-memory bus between the L1 cache controller (host) and the memory (device).
interface axi_bus_rw;
  import line_mem_responder_pkg::*;

  logic [31:0] read_addr;
  logic        read_addr_valid;
  logic        read_addr_ready;
  line_t       read_data;
  logic        read_data_valid;
  logic [31:0] write_addr;
  logic        write_addr_valid;
  line_t       write_data;
  strobe_t     strobe;
  logic        write_addr_ready;
  logic        write_resp_valid;
  logic [2:0]  size;
  logic        lu;

  modport device (
    input  read_addr, read_addr_valid, write_addr, write_addr_valid,
           write_data, strobe, size, lu,
    output read_addr_ready, read_data, read_data_valid,
           write_addr_ready, write_resp_valid
  );

  modport host (
    output read_addr, read_addr_valid, write_addr, write_addr_valid,
           write_data, strobe, size, lu,
    input  read_addr_ready, read_data, read_data_valid,
           write_addr_ready, write_resp_valid
  );

endinterface

// File: rtl/line_mem_responder_line_ram.sv
// Single-port line RAM: synchronous read, byte-enabled write.
module line_mem_responder_line_ram
  import line_mem_responder_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  strobe_t                  be,
  input  line_t                    wdata,
  output line_t                    rdata
);

  line_t mem [DEPTH];

  // NOTE: the array and its output register have no reset; clearing a block RAM
  // costs a cycle per line and would stop the tools from mapping it to RAM macros.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Device end of the cache-memory bus: serves one line read or write at a time after a fixed latency.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int    DEPTH      = 4096,
  parameter int    LATENCY    = 4,
  parameter bit    USE_STROBE = 1'b0,
  parameter string INIT_FILE  = ""
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  axi_bus_rw.device        bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] COUNT_INIT = COUNT_W'(LATENCY - 1);

  typedef logic [IDX_W-1:0] idx_t;

  mem_state_e         state;
  logic [COUNT_W-1:0] count;
  idx_t               idx_q;
  line_t              wdata_q;
  strobe_t            strobe_q;
  logic               ready_q;
  logic               rd_valid_q;
  logic               wr_resp_q;
  line_t              hold_q;

  logic    rd_accept;
  logic    wr_accept;
  logic    ram_en;
  logic    ram_we;
  idx_t    ram_addr;
  strobe_t ram_be;
  line_t   ram_q;

  // ready_q is high exactly in IDLE, so reads win simply by being tested first.
  assign rd_accept = ready_q && bus.read_addr_valid;
  assign wr_accept = ready_q && !bus.read_addr_valid && bus.write_addr_valid;

  // The single RAM port reads at read acceptance and writes on the write's final cycle.
  assign ram_we   = (state == WR_BUSY) && (count == '0);
  assign ram_en   = rd_accept || ram_we;
  assign ram_addr = ram_we ? idx_q : bus.read_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign ram_be   = USE_STROBE ? strobe_q : '1;

  line_mem_responder_line_ram #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // NOTE: ready is a register rather than a decode of state, so it is 0 while in
  // reset and the response cycle still sees it low before IDLE is re-entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      count      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      strobe_q   <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_resp_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_resp_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (rd_accept) begin
            idx_q      <= bus.read_addr[IDX_W+OFFSET_W-1:OFFSET_W];
            count      <= COUNT_INIT;
            ready_q    <= 1'b0;
            rd_valid_q <= (COUNT_INIT == '0);
            state      <= RD_BUSY;
          end else if (wr_accept) begin
            idx_q     <= bus.write_addr[IDX_W+OFFSET_W-1:OFFSET_W];
            wdata_q   <= bus.write_data;
            strobe_q  <= bus.strobe;
            count     <= COUNT_INIT;
            ready_q   <= 1'b0;
            wr_resp_q <= (COUNT_INIT == '0);
            state     <= WR_BUSY;
          end
        end
        RD_BUSY, WR_BUSY: begin
          if (count == '0) begin
            if (state == RD_BUSY) hold_q <= ram_q;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            count <= count - 1'b1;
            if (count == COUNT_W'(1)) begin
              rd_valid_q <= (state == RD_BUSY);
              wr_resp_q  <= (state == WR_BUSY);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // During the response cycle the RAM output is still live; afterwards the held copy is shown.
  assign bus.read_data        = rd_valid_q ? ram_q : hold_q;
  assign bus.read_data_valid  = rd_valid_q;
  assign bus.write_resp_valid = wr_resp_q;
  assign bus.read_addr_ready  = ready_q;
  assign bus.write_addr_ready = ready_q;

  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.lu,
                         bus.read_addr[31:IDX_W+OFFSET_W], bus.read_addr[OFFSET_W-1:0],
                         bus.write_addr[31:IDX_W+OFFSET_W], bus.write_addr[OFFSET_W-1:0]};

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: table of line transactions plus hand-written corner sequences.
module tb_line_mem_responder;
  import line_mem_responder_pkg::*;

  localparam int LAT = 4;

  localparam line_t LINE_A = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam line_t LINE_5 = {32{4'h5}};
  localparam line_t LINE_AA = {32{4'hA}};
  localparam line_t LINE_C = {32{4'hC}};
  localparam line_t JUNK   = {4{32'hBAD0_BAD0}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_bus_rw bus ();
  axi_bus_rw bus_s ();

  line_mem_responder #(
    .DEPTH(4096), .LATENCY(LAT), .USE_STROBE(1'b0), .INIT_FILE("")
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  line_mem_responder #(
    .DEPTH(4096), .LATENCY(LAT), .USE_STROBE(1'b1), .INIT_FILE("")
  ) u_dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    line_t       data;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input line_t got, input line_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    check(name, {127'b0, got}, {127'b0, exp});
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    check(name, line_t'(got), line_t'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main bus, requester drops valid right after the handshake.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input line_t data,
                        input string name);
    int   lat;
    logic busy_ready;
    check_bit({name, " ready"}, wr ? bus.write_addr_ready : bus.read_addr_ready, 1'b1);
    if (wr) begin
      bus.write_addr = addr; bus.write_data = data; bus.strobe = '1; bus.write_addr_valid = 1'b1;
    end else begin
      bus.read_addr = addr; bus.read_addr_valid = 1'b1;
    end
    step();
    bus.read_addr_valid = 1'b0; bus.write_addr_valid = 1'b0;
    bus.write_data = JUNK; bus.read_addr = 32'hFFFF_FFF0;
    busy_ready = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.read_addr_ready || bus.write_addr_ready) busy_ready = 1'b1;
      if (wr ? bus.write_resp_valid : bus.read_data_valid) begin
        lat = k;
        break;
      end
      step();
    end
    check_int({name, " latency"}, lat, LAT);
    check_bit({name, " ready low while busy"}, busy_ready, 1'b0);
    if (!wr) check({name, " data"}, bus.read_data, data);
    step();
    check_bit({name, " single pulse"}, wr ? bus.write_resp_valid : bus.read_data_valid, 1'b0);
    if (!wr) check({name, " data held"}, bus.read_data, data);
  endtask

  // Transaction on the strobe-enabled instance; returns measured latency and read data.
  task automatic s_txn(input logic wr, input logic [31:0] addr, input line_t data,
                       input strobe_t strb, output int lat, output line_t rd);
    if (wr) begin
      bus_s.write_addr = addr; bus_s.write_data = data; bus_s.strobe = strb;
      bus_s.write_addr_valid = 1'b1;
    end else begin
      bus_s.read_addr = addr; bus_s.read_addr_valid = 1'b1;
    end
    step();
    bus_s.read_addr_valid = 1'b0; bus_s.write_addr_valid = 1'b0; bus_s.write_data = JUNK;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 20; k++) begin
      if (wr ? bus_s.write_resp_valid : bus_s.read_data_valid) begin
        lat = k;
        rd  = bus_s.read_data;
        break;
      end
      step();
    end
    step();
  endtask

  // Requester keeps read valid high and drops it on the drop_at-th response pulse.
  task automatic hold_read(input logic [31:0] addr, input int drop_at, input line_t exp,
                           input string name);
    int pulses;
    int first_at;
    int second_at;
    pulses = 0; first_at = 0; second_at = 0;
    bus.read_addr = addr;
    bus.read_addr_valid = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      if (bus.read_data_valid) begin
        pulses++;
        if (pulses == 1) first_at = k;
        if (pulses == 2) second_at = k;
        check({name, " data"}, bus.read_data, exp);
        if (pulses == drop_at) bus.read_addr_valid = 1'b0;
      end
      step();
    end
    bus.read_addr_valid = 1'b0;
    check_int({name, " pulse count"}, pulses, drop_at);
    check_int({name, " first pulse cycle"}, first_at, LAT);
    if (drop_at == 2) check_int({name, " second pulse cycle"}, second_at, 2 * LAT + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    lat;
    int    lat2;
    logic  flag;
    line_t rd;

    bus.read_addr = '0; bus.read_addr_valid = 1'b0; bus.write_addr = '0;
    bus.write_addr_valid = 1'b0; bus.write_data = '0; bus.strobe = '0;
    bus.size = '0; bus.lu = 1'b0;
    bus_s.read_addr = '0; bus_s.read_addr_valid = 1'b0; bus_s.write_addr = '0;
    bus_s.write_addr_valid = 1'b0; bus_s.write_data = '0; bus_s.strobe = '0;
    bus_s.size = '0; bus_s.lu = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0100, LINE_A,  "preload line 0x10"};
    vecs[1] = '{1'b0, 32'h0000_0100, LINE_A,  "read 0x100"};
    vecs[2] = '{1'b1, 32'h0000_0200, LINE_AA, "write 0x200"};
    vecs[3] = '{1'b0, 32'h0000_0200, LINE_AA, "read 0x200"};
    vecs[4] = '{1'b0, 32'h0000_020C, LINE_AA, "read 0x20C offset ignored"};
    vecs[5] = '{1'b1, 32'h0001_0200, LINE_5,  "write aliasing 0x10200"};
    vecs[6] = '{1'b0, 32'h0000_0200, LINE_5,  "read 0x200 after alias"};
    vecs[7] = '{1'b0, 32'h0000_0100, LINE_A,  "reread 0x100"};

    // Reset state
    step(); step();
    check_bit("reset read_addr_ready", bus.read_addr_ready, 1'b0);
    check_bit("reset write_addr_ready", bus.write_addr_ready, 1'b0);
    check_bit("reset read_data_valid", bus.read_data_valid, 1'b0);
    check_bit("reset write_resp_valid", bus.write_resp_valid, 1'b0);
    check("reset read_data", bus.read_data, '0);
    rst_n = 1'b1;
    step();
    check_bit("idle ready after reset", bus.read_addr_ready, 1'b1);

    for (int i = 0; i < 8; i++) do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].name);

    // Read and write together: read first, write in the first IDLE cycle after the response
    bus.read_addr = 32'h0000_0100; bus.read_addr_valid = 1'b1;
    bus.write_addr = 32'h0000_0400; bus.write_data = LINE_C; bus.strobe = '1;
    bus.write_addr_valid = 1'b1;
    step();
    lat = 0; flag = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.write_addr_ready) flag = 1'b1;
      if (bus.read_data_valid) begin lat = k; break; end
      step();
    end
    check_int("collision read latency", lat, LAT);
    check("collision read data", bus.read_data, LINE_A);
    check_bit("collision write ready low", flag, 1'b0);
    check_bit("collision no early write resp", bus.write_resp_valid, 1'b0);
    bus.read_addr_valid = 1'b0;
    step();
    check_bit("collision write ready in idle", bus.write_addr_ready, 1'b1);
    step();
    bus.write_addr_valid = 1'b0; bus.write_data = JUNK;
    lat2 = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.write_resp_valid) begin lat2 = k; break; end
      step();
    end
    check_int("collision write latency", lat2, LAT);
    step();
    do_txn(1'b0, 32'h0000_0400, LINE_C, "read collision line");

    // Held read valid
    hold_read(32'h0000_0200, 1, LINE_5, "held read drop on pulse");
    hold_read(32'h0000_0100, 2, LINE_A, "held read kept high");

    // Reset two cycles into a write
    bus.write_addr = 32'h0000_0200; bus.write_data = {4{32'hDEAD_BEEF}};
    bus.strobe = '1; bus.write_addr_valid = 1'b1;
    step();
    bus.write_addr_valid = 1'b0; bus.write_data = JUNK;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_bit("mid reset read_addr_ready", bus.read_addr_ready, 1'b0);
    check_bit("mid reset write_addr_ready", bus.write_addr_ready, 1'b0);
    check_bit("mid reset write_resp_valid", bus.write_resp_valid, 1'b0);
    check("mid reset read_data", bus.read_data, '0);
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.write_resp_valid || bus.read_data_valid) flag = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.write_resp_valid || bus.read_data_valid) flag = 1'b1;
    end
    check_bit("aborted write no response", flag, 1'b0);
    do_txn(1'b0, 32'h0000_0200, LINE_5, "line kept after aborted write");

    // Byte strobes on the USE_STROBE instance
    s_txn(1'b1, 32'h0000_0300, '0, 16'hFFFF, lat, rd);
    check_int("strobe clear latency", lat, LAT);
    s_txn(1'b1, 32'h0000_0300, '1, 16'h000F, lat, rd);
    check_int("strobe low bytes latency", lat, LAT);
    s_txn(1'b0, 32'h0000_0300, '0, '0, lat, rd);
    check("strobe low bytes data", rd, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    s_txn(1'b1, 32'h0000_0300, {4{32'h1234_5678}}, 16'hF000, lat, rd);
    s_txn(1'b0, 32'h0000_0300, '0, '0, lat, rd);
    check("strobe high bytes data", rd, 128'h1234_5678_0000_0000_0000_0000_FFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
